// File: rtl/pio_edge_capture_multi.sv
// Multi-bit input PIO with Avalon-MM slave: synchronised inputs, per-bit
// rise/fall edge capture (W1C), saturating event counter and masked level irq.
module pio_edge_capture_multi #(
    parameter int unsigned      WIDTH         = 8,
    parameter int unsigned      SYNC_STAGES   = 2,
    parameter int unsigned      CNT_WIDTH     = 16,
    parameter logic [WIDTH-1:0] RISE_EN_RESET = '1,
    parameter logic [WIDTH-1:0] FALL_EN_RESET = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq,
    output logic [31:0]      readdata
);

    typedef enum logic [2:0] {
        A_DATA  = 3'd0,
        A_RISE  = 3'd1,
        A_MASK  = 3'd2,
        A_CAP   = 3'd3,
        A_FALL  = 3'd4,
        A_COUNT = 3'd5
    } addr_e;

    logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]     prev_q;
    logic [WIDTH-1:0]     rise_q, rise_d;
    logic [WIDTH-1:0]     fall_q, fall_d;
    logic [WIDTH-1:0]     mask_q, mask_d;
    logic [WIDTH-1:0]     cap_q, cap_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          rdata_q, rdata_d;

    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] sync_last;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] w1c;
    logic             any_ev;
    logic             wdata_unused;

    assign wr           = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign wdata_unused = ^{writedata, 1'b0};
    assign sync_last    = sync_q[SYNC_STAGES-1];
    assign ev           = (sync_last & ~prev_q & rise_q) | (~sync_last & prev_q & fall_q);
    assign any_ev       = |ev;
    assign w1c          = (wr && address == A_CAP) ? wdata : '0;

    assign irq      = |(cap_q & mask_q);
    assign readdata = rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_last;
        end
    end

    always_comb begin
        rise_d = rise_q;
        fall_d = fall_q;
        mask_d = mask_q;
        if (wr) begin
            case (address)
                A_RISE:  rise_d = wdata;
                A_MASK:  mask_d = wdata;
                A_FALL:  fall_d = wdata;
                default: ;
            endcase
        end
    end

    // A new event on a bit wins over a simultaneous write-1-to-clear.
    assign cap_d = (cap_q & ~w1c) | ev;

    always_comb begin
        cnt_d = cnt_q;
        if (wr && address == A_COUNT) begin
            cnt_d = any_ev ? CNT_WIDTH'(1) : '0;
        end else if (any_ev && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        rdata_d = '0;
        case (address)
            A_DATA:  rdata_d = 32'(sync_last);
            A_RISE:  rdata_d = 32'(rise_q);
            A_MASK:  rdata_d = 32'(mask_q);
            A_CAP:   rdata_d = 32'(cap_q);
            A_FALL:  rdata_d = 32'(fall_q);
            A_COUNT: rdata_d = 32'(cnt_q);
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_q  <= RISE_EN_RESET;
            fall_q  <= FALL_EN_RESET;
            mask_q  <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_pio_edge_capture_multi.sv
// Self-checking bench for pio_edge_capture_multi: reset table, directed corner
// sequences and randomized traffic against a history-queue reference model.
module tb_pio_edge_capture_multi;

    localparam int unsigned W    = 8;
    localparam int unsigned S    = 2;
    localparam int unsigned CMAX = 65535;
    localparam int unsigned C2MAX = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [W-1:0]  in_port = '0;
    logic          irq, irq2;
    logic [31:0]   readdata, readdata2;

    int unsigned checks = 0;
    int unsigned errors = 0;

    pio_edge_capture_multi #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .irq(irq), .readdata(readdata)
    );

    pio_edge_capture_multi #(.WIDTH(W), .SYNC_STAGES(S), .CNT_WIDTH(2)) dut_c2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .irq(irq2), .readdata(readdata2)
    );

    always #5 clk = ~clk;

    // Reference model: input history queue, hist[0] = most recent sample.
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_rise, m_fall, m_mask, m_cap;
    int unsigned  m_cnt, m_cnt2;
    logic [31:0]  m_rd, m_rd2;
    logic         m_irq;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;
    rd_vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist = {};
        for (int i = 0; i <= int'(S); i++) m_hist.push_back('0);
        m_rise = '1; m_fall = '0; m_mask = '0; m_cap = '0;
        m_cnt = 0; m_cnt2 = 0; m_rd = '0; m_rd2 = '0; m_irq = 1'b0;
    endtask

    task automatic model_step();
        logic [W-1:0] synced, older, ev, wd;
        logic wr;
        synced = m_hist[S-1];
        older  = m_hist[S];
        ev = (synced & ~older & m_rise) | (~synced & older & m_fall);
        wr = chipselect && !write_n;
        wd = writedata[W-1:0];
        m_rd = '0;
        case (address)
            3'd0: m_rd = 32'(synced);
            3'd1: m_rd = 32'(m_rise);
            3'd2: m_rd = 32'(m_mask);
            3'd3: m_rd = 32'(m_cap);
            3'd4: m_rd = 32'(m_fall);
            default: m_rd = '0;
        endcase
        m_rd2 = m_rd;
        if (address == 3'd5) begin
            m_rd  = m_cnt;
            m_rd2 = m_cnt2;
        end
        if (wr) begin
            case (address)
                3'd1: m_rise = wd;
                3'd2: m_mask = wd;
                3'd3: m_cap  = m_cap & ~wd;
                3'd4: m_fall = wd;
                default: ;
            endcase
        end
        m_cap = m_cap | ev;
        if (wr && address == 3'd5) begin
            m_cnt  = (ev != 0) ? 1 : 0;
            m_cnt2 = m_cnt;
        end else if (ev != 0) begin
            if (m_cnt < CMAX) m_cnt++;
            if (m_cnt2 < C2MAX) m_cnt2++;
        end
        m_hist.push_front(in_port);
        void'(m_hist.pop_back());
        m_irq = |(m_cap & m_mask);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("rd", readdata, m_rd);
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
        chk("rd_c2", readdata2, m_rd2);
        chk("irq_c2", {31'd0, irq2}, {31'd0, m_irq});
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cycle();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a;
        cycle();
    endtask

    initial begin
        logic [W-1:0] seq5[9];
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // 1: reset values through the read path
        tbl[0] = '{3'd0, 32'h00}; tbl[1] = '{3'd1, 32'hFF};
        tbl[2] = '{3'd2, 32'h00}; tbl[3] = '{3'd3, 32'h00};
        tbl[4] = '{3'd4, 32'h00}; tbl[5] = '{3'd5, 32'h00};
        tbl[6] = '{3'd6, 32'h00}; tbl[7] = '{3'd7, 32'h00};
        chk("reset_irq", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd(tbl[i].addr);
            chk($sformatf("reset_rd%0d", i), readdata, tbl[i].exp);
        end

        // 2: rising edge latency and W1C clearing irq
        wr(3'd2, 32'h01);
        in_port = 8'h01;
        cycle(); chk("lat_k", {31'd0, irq}, 32'd0);
        cycle(); chk("lat_k1", {31'd0, irq}, 32'd0);
        cycle(); chk("lat_k2", {31'd0, irq}, 32'd1);
        rd(3'd3); chk("cap_bit0", readdata, 32'h01);
        rd(3'd5); chk("cnt_one", readdata, 32'd1);
        wr(3'd3, 32'h01); chk("w1c_irq", {31'd0, irq}, 32'd0);

        // 3: falling-edge only on bit 7
        wr(3'd1, 32'h00); wr(3'd4, 32'h80); wr(3'd5, 32'h0);
        in_port = 8'h81; cycles(5);
        in_port = 8'h01; cycles(4);
        rd(3'd3); chk("fall_cap", readdata, 32'h80);
        rd(3'd5); chk("fall_cnt", readdata, 32'd1);

        // 4: clear and new event in the same cycle
        wr(3'd1, 32'h01); wr(3'd4, 32'h00); wr(3'd3, 32'hFF);
        in_port = 8'h00; cycles(3);
        in_port = 8'h01; cycles(3);
        in_port = 8'h00; cycles(2);
        in_port = 8'h01; cycles(2);
        wr(3'd3, 32'h01);
        rd(3'd3); chk("ev_wins", readdata, 32'h01);
        wr(3'd3, 32'h02);
        rd(3'd3); chk("w1c_other", readdata, 32'h01);

        // 5: counter saturation and write-with-event
        wr(3'd1, 32'h03); wr(3'd4, 32'h00); wr(3'd5, 32'h0);
        seq5 = '{8'h00, 8'h01, 8'h03, 8'h00, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02};
        for (int i = 0; i < 9; i++) begin
            in_port = seq5[i]; cycles(2);
        end
        cycle();
        rd(3'd5);
        chk("cnt5", readdata, 32'd5);
        chk("cnt_sat", readdata2, 32'd3);
        in_port = 8'h00; cycles(2);
        in_port = 8'h01; cycles(2);
        wr(3'd5, 32'h0);
        rd(3'd5);
        chk("cnt_load1", readdata, 32'd1);
        chk("cnt_load1_c2", readdata2, 32'd1);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) == 0) in_port = W'($urandom);
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = $urandom_range(0, 1) == 0;
            address    = 3'($urandom);
            writedata  = $urandom;
            cycle();
        end
        chipselect = 1'b0; write_n = 1'b1;

        // 6: async reset mid-cycle, then input high at release
        wr(3'd1, 32'hFF); wr(3'd4, 32'h00); wr(3'd2, 32'h0F);
        in_port = 8'h00; cycles(4);
        wr(3'd3, 32'hFF); wr(3'd5, 32'h0);
        for (int i = 0; i < 6; i++) begin
            in_port = 8'h01; cycles(2);
            in_port = 8'h00; cycles(2);
        end
        in_port = 8'h0F; cycles(4);
        rd(3'd3); chk("pre_cap", readdata, 32'h0F);
        rd(3'd5); chk("pre_cnt", readdata, 32'd7);
        chk("pre_irq", {31'd0, irq}, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_rd", readdata, 32'd0);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        chk("arst_rd_c2", readdata2, 32'd0);
        model_reset();
        in_port = 8'hFF;
        @(posedge clk);
        #1 reset_n = 1'b1;
        address = 3'd3;
        cycles(3);
        rd(3'd3); chk("rel_cap", readdata, 32'hFF);
        rd(3'd5); chk("rel_cnt", readdata, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
